// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - two-digit seven-segment scan driver with pattern decode
//
// Purpose:
//   Takes a static 16-bit active-low seven-segment word (tens byte high,
//   units byte low) and time-multiplexes it onto one shared segment bus with
//   two active-low digit enables. Blank gaps are inserted between digit slots
//   to avoid ghosting. The word is also decoded back to a binary value, and
//   illegal patterns are flagged.
//
// Parameters:
//   SCAN_DIV     - clock cycles per digit slot (blank + show), > BLANK_CYCLES
//   BLANK_CYCLES - all-off cycles at the start of each slot, >= 1
//   LZ_SUPPRESS  - 1: a tens digit of 0 is not lit
//
// Ports:
//   clk          in   1   system clock
//   rst_n        in   1   asynchronous active-low reset
//   display_led  in  16   [15:8] tens, [7:0] units; active-low, bit7 = dp
//   err_clr      in   1   synchronous clear of pattern_err
//   seg_out      out  8   shared segment bus, active-low
//   an_n         out  2   digit enables, active-low; [1] tens, [0] units
//   digit_value  out  7   decoded value 0..99
//   digit_valid  out  1   both digits legal in the last registered sample
//   value_chg    out  1   one-cycle pulse when digit_value takes a new value
//   pattern_err  out  1   sticky illegal-pattern flag

module seg7_scan_driver #(
  parameter int SCAN_DIV     = 10000,
  parameter int BLANK_CYCLES = 100,
  parameter int LZ_SUPPRESS  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] display_led,
  input  logic        err_clr,
  output logic [7:0]  seg_out,
  output logic [1:0]  an_n,
  output logic [6:0]  digit_value,
  output logic        digit_valid,
  output logic        value_chg,
  output logic        pattern_err
);

  localparam int SHOW_CYCLES = SCAN_DIV - BLANK_CYCLES;
  localparam int CW          = $clog2(SCAN_DIV + 1);

  localparam logic [7:0] SEG_OFF  = 8'hFF;
  localparam logic [7:0] SEG_DASH = 8'hBF;
  localparam logic [7:0] SEG_ZERO = 8'hC0;

  typedef enum logic [1:0] {
    BLANK_T = 2'd0,
    SHOW_T  = 2'd1,
    BLANK_U = 2'd2,
    SHOW_U  = 2'd3
  } state_e;

  // Pattern -> digit; 4'hF marks any byte that is not one of the ten glyphs.
  function automatic logic [3:0] seg_to_digit(input logic [7:0] p);
    logic [3:0] d;
    case (p)
      8'hC0:   d = 4'd0;
      8'hF9:   d = 4'd1;
      8'hA4:   d = 4'd2;
      8'hB0:   d = 4'd3;
      8'h99:   d = 4'd4;
      8'h92:   d = 4'd5;
      8'h82:   d = 4'd6;
      8'hF8:   d = 4'd7;
      8'h80:   d = 4'd8;
      8'h90:   d = 4'd9;
      default: d = 4'hF;
    endcase
    return d;
  endfunction

  function automatic logic [7:0] sanitize(input logic [7:0] p);
    return (seg_to_digit(p) == 4'hF) ? SEG_DASH : p;
  endfunction

  // Registered state
  logic [15:0]   in_q,          in_d;
  logic          armed_q,       armed_d;
  logic [6:0]    digit_value_q, digit_value_d;
  logic          digit_valid_q, digit_valid_d;
  logic          value_chg_q,   value_chg_d;
  logic          pattern_err_q, pattern_err_d;
  state_e        state_q,       state_d;
  logic [CW-1:0] cnt_q,         cnt_d;
  logic [7:0]    seg_q,         seg_d;
  logic [1:0]    an_q,          an_d;

  // Decode of the registered sample
  logic [3:0] tens_dig;
  logic [3:0] units_dig;
  logic       both_legal;
  logic [6:0] value_calc;

  always_comb begin
    tens_dig   = seg_to_digit(in_q[15:8]);
    units_dig  = seg_to_digit(in_q[7:0]);
    both_legal = (tens_dig != 4'hF) && (units_dig != 4'hF);
    // tens*10 as (tens<<3)+(tens<<1); only evaluated for legal digits, so <= 99.
    value_calc = ({3'b000, tens_dig} << 3) + ({3'b000, tens_dig} << 1)
               + {3'b000, units_dig};
  end

  always_comb begin
    in_d          = display_led;
    armed_d       = 1'b1;
    digit_value_d = digit_value_q;
    digit_valid_d = digit_valid_q;
    value_chg_d   = 1'b0;
    pattern_err_d = pattern_err_q;

    // armed_q is low for the first edge after reset, so the FFFF reset value
    // of in_q is never decoded.
    if (armed_q) begin
      if (both_legal) begin
        digit_valid_d = 1'b1;
        digit_value_d = value_calc;
        value_chg_d   = (value_calc != digit_value_q);
      end else begin
        digit_valid_d = 1'b0;
      end
    end

    // Setting wins over clearing in the same cycle.
    if (armed_q && !both_legal) begin
      pattern_err_d = 1'b1;
    end else if (err_clr) begin
      pattern_err_d = 1'b0;
    end
  end

  // Scan sequencing: one down-counter times every state and reloads on each
  // transition. The displayed pattern is captured into seg_q on the edge that
  // enters a SHOW state and held for the slot.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q - CW'(1);
    seg_d   = seg_q;
    an_d    = an_q;

    if (cnt_q == CW'(1)) begin
      case (state_q)
        BLANK_T: begin
          state_d = SHOW_T;
          cnt_d   = CW'(SHOW_CYCLES);
          if ((LZ_SUPPRESS != 0) && (in_q[15:8] == SEG_ZERO)) begin
            an_d  = 2'b11;
            seg_d = SEG_OFF;
          end else begin
            an_d  = 2'b01;
            seg_d = sanitize(in_q[15:8]);
          end
        end
        SHOW_T: begin
          state_d = BLANK_U;
          cnt_d   = CW'(BLANK_CYCLES);
          an_d    = 2'b11;
          seg_d   = SEG_OFF;
        end
        BLANK_U: begin
          state_d = SHOW_U;
          cnt_d   = CW'(SHOW_CYCLES);
          an_d    = 2'b10;
          seg_d   = sanitize(in_q[7:0]);
        end
        SHOW_U: begin
          state_d = BLANK_T;
          cnt_d   = CW'(BLANK_CYCLES);
          an_d    = 2'b11;
          seg_d   = SEG_OFF;
        end
        default: begin
          state_d = BLANK_T;
          cnt_d   = CW'(BLANK_CYCLES);
          an_d    = 2'b11;
          seg_d   = SEG_OFF;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_q          <= 16'hFFFF;
      armed_q       <= 1'b0;
      digit_value_q <= 7'd0;
      digit_valid_q <= 1'b0;
      value_chg_q   <= 1'b0;
      pattern_err_q <= 1'b0;
      state_q       <= BLANK_T;
      cnt_q         <= CW'(BLANK_CYCLES);
      seg_q         <= SEG_OFF;
      an_q          <= 2'b11;
    end else begin
      in_q          <= in_d;
      armed_q       <= armed_d;
      digit_value_q <= digit_value_d;
      digit_valid_q <= digit_valid_d;
      value_chg_q   <= value_chg_d;
      pattern_err_q <= pattern_err_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      seg_q         <= seg_d;
      an_q          <= an_d;
    end
  end

  assign seg_out     = seg_q;
  assign an_n        = an_q;
  assign digit_value = digit_value_q;
  assign digit_valid = digit_valid_q;
  assign value_chg   = value_chg_q;
  assign pattern_err = pattern_err_q;

endmodule
